// File: rtl/miyajiro_cpu.sv
// MIYAJIRO CPU host-link shell: UART RX/TX, boot loader into instruction memory,
// and stdin FIFO / stdout byte channels toward the execution core.
module miyajiro_cpu #(
  parameter int unsigned CLKS_PER_BIT  = 868,
  parameter int unsigned IMEM_WORDS    = 1024,
  parameter int unsigned IN_FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cpu_uart_rxd,
  output logic                          cpu_uart_txd,
  input  logic [$clog2(IMEM_WORDS)-1:0] imem_raddr,
  output logic [31:0]                   imem_rdata,
  output logic                          boot_done,
  output logic                          in_valid,
  output logic [7:0]                    in_data,
  input  logic                          in_ready,
  input  logic                          out_valid,
  input  logic [7:0]                    out_data,
  output logic                          out_ready
);

  localparam int unsigned AW = $clog2(IMEM_WORDS);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned FW = $clog2(IN_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FW:0]   FIFO_FULL = (FW+1)'(IN_FIFO_DEPTH);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [2:0] {L_SEND_SYNC, L_RX_SIZE, L_RX_PROG, L_SEND_ACK, L_WAIT_ACK, L_RUN} ld_state_t;

  rx_state_t   rx_state;
  logic        rx_sync;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic [7:0]  rdata;
  logic        rdata_ready;
  logic        ferr;

  tx_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;

  ld_state_t   ld_state;
  logic [31:0] size;
  logic [31:0] byte_cnt;
  logic [31:0] word_acc;

  logic [31:0] imem [IMEM_WORDS];
  logic [7:0]  fifo [IN_FIFO_DEPTH];
  logic [FW-1:0] wr_ptr;
  logic [FW-1:0] rd_ptr;
  logic [FW:0] fifo_count;

  logic        rx_ok_c;
  logic [1:0]  lane_c;
  logic [31:0] word_next_c;
  logic        last_byte_c;
  logic        mem_we_c;
  logic [AW-1:0] mem_waddr_c;
  logic        push_c;
  logic        pop_c;
  logic [FW:0] count_next_c;

  // Receiver: mid-bit sampling; after a framing error wait for the line to idle
  // high so the low stop bit is not mistaken for a new start bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_sync     <= 1'b1;
      rx_state    <= R_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rdata       <= '0;
      rdata_ready <= 1'b0;
      ferr        <= 1'b0;
    end else begin
      rx_sync     <= cpu_uart_rxd;
      rdata_ready <= 1'b0;
      case (rx_state)
        R_IDLE: if (!rx_sync) begin
          rx_state <= R_START;
          rx_cnt   <= CW'(1);
        end
        R_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_sync ? R_IDLE : R_DATA;
        end else rx_cnt <= rx_cnt + CW'(1);
        R_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= R_STOP;
        end else rx_cnt <= rx_cnt + CW'(1);
        R_STOP: if (rx_cnt == BIT_LAST) begin
          rx_cnt      <= '0;
          rdata       <= rx_shift;
          rdata_ready <= 1'b1;
          ferr        <= !rx_sync;
          rx_state    <= rx_sync ? R_IDLE : R_BREAK;
        end else rx_cnt <= rx_cnt + CW'(1);
        R_BREAK: if (rx_sync) rx_state <= R_IDLE;
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Transmitter: byte latched on accept; tx_done pulses as the stop bit ends.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state     <= T_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      cpu_uart_txd <= 1'b1;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        T_IDLE: if (tx_start) begin
          tx_shift     <= tx_data;
          cpu_uart_txd <= 1'b0;
          tx_busy      <= 1'b1;
          tx_cnt       <= '0;
          tx_state     <= T_START;
        end
        T_START: if (tx_cnt == BIT_LAST) begin
          tx_cnt       <= '0;
          tx_bit       <= '0;
          cpu_uart_txd <= tx_shift[0];
          tx_state     <= T_DATA;
        end else tx_cnt <= tx_cnt + CW'(1);
        T_DATA: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            cpu_uart_txd <= 1'b1;
            tx_state     <= T_STOP;
          end else begin
            cpu_uart_txd <= tx_shift[1];
            tx_shift     <= tx_shift >> 1;
            tx_bit       <= tx_bit + 3'd1;
          end
        end else tx_cnt <= tx_cnt + CW'(1);
        T_STOP: if (tx_cnt == BIT_LAST) begin
          tx_busy  <= 1'b0;
          tx_done  <= 1'b1;
          tx_state <= T_IDLE;
        end else tx_cnt <= tx_cnt + CW'(1);
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // Program-byte packing and FIFO control decode.
  always_comb begin
    rx_ok_c     = rdata_ready && !ferr;
    lane_c      = byte_cnt[1:0];
    word_next_c = (lane_c == 2'd0) ? {24'd0, rdata}
                                   : (word_acc | (32'(rdata) << {lane_c, 3'b000}));
    last_byte_c = ((byte_cnt + 32'd1) == size);
    mem_waddr_c = byte_cnt[AW+1:2];
    mem_we_c    = reset_n && (ld_state == L_RX_PROG) && rx_ok_c
                  && (byte_cnt[31:2] < 30'(IMEM_WORDS))
                  && ((lane_c == 2'd3) || last_byte_c);
    pop_c       = in_valid && in_ready;
    push_c      = reset_n && (ld_state == L_RUN) && rx_ok_c
                  && ((fifo_count != FIFO_FULL) || pop_c);
    count_next_c = fifo_count;
    if (push_c && !pop_c)      count_next_c = fifo_count + (FW+1)'(1);
    else if (pop_c && !push_c) count_next_c = fifo_count - (FW+1)'(1);
  end

  // Boot loader and stdout arbitration of the transmitter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ld_state  <= L_SEND_SYNC;
      size      <= '0;
      byte_cnt  <= '0;
      word_acc  <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      boot_done <= 1'b0;
      out_ready <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      out_ready <= 1'b0;
      case (ld_state)
        L_SEND_SYNC: begin
          tx_start <= 1'b1;
          tx_data  <= 8'h99;
          byte_cnt <= '0;
          ld_state <= L_RX_SIZE;
        end
        L_RX_SIZE: if (rx_ok_c) begin
          size     <= {rdata, size[31:8]};
          byte_cnt <= byte_cnt + 32'd1;
          if (byte_cnt[1:0] == 2'd3) begin
            byte_cnt <= '0;
            ld_state <= ({rdata, size[31:8]} == 32'd0) ? L_SEND_ACK : L_RX_PROG;
          end
        end
        L_RX_PROG: if (rx_ok_c) begin
          word_acc <= word_next_c;
          byte_cnt <= byte_cnt + 32'd1;
          if (last_byte_c) ld_state <= L_SEND_ACK;
        end
        L_SEND_ACK: if (!tx_busy && !tx_start) begin
          tx_start <= 1'b1;
          tx_data  <= 8'hAA;
          ld_state <= L_WAIT_ACK;
        end
        L_WAIT_ACK: if (tx_done) begin
          boot_done <= 1'b1;
          ld_state  <= L_RUN;
        end
        L_RUN: begin
          if (out_valid && out_ready) begin
            tx_start <= 1'b1;
            tx_data  <= out_data;
          end else begin
            out_ready <= !tx_busy && !tx_start;
          end
        end
        default: ld_state <= L_SEND_SYNC;
      endcase
    end
  end

  // Instruction memory: contents survive reset, read port has one cycle latency.
  always_ff @(posedge clk) begin
    if (mem_we_c) imem[mem_waddr_c] <= word_next_c;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) imem_rdata <= '0;
    else          imem_rdata <= imem[imem_raddr];
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo[wr_ptr] <= rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_valid   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + FW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + FW'(1);
      fifo_count <= count_next_c;
      in_valid   <= (count_next_c != '0);
    end
  end

  assign in_data = fifo[rd_ptr];

endmodule

// File: tb/tb_miyajiro_cpu.sv
// Directed bench for miyajiro_cpu: host UART driver, TX frame monitor with an
// expected-byte scoreboard, boot loads, stdin overflow and stdout frames.
module tb_miyajiro_cpu;
  localparam int unsigned CPB   = 8;
  localparam int unsigned WORDS = 1024;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rxd;
  logic        txd;
  logic [9:0]  imem_raddr;
  logic [31:0] imem_rdata;
  logic        boot_done;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_tx[$];
  logic [7:0]  exp_in[$];
  logic [31:0] prog[32];

  always #5 clk = ~clk;

  miyajiro_cpu #(.CLKS_PER_BIT(CPB), .IMEM_WORDS(WORDS), .IN_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_uart_rxd(rxd), .cpu_uart_txd(txd),
    .imem_raddr(imem_raddr), .imem_rdata(imem_rdata), .boot_done(boot_done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_cycles(CPB);
    end
    rxd = stop;
    wait_cycles(CPB);
    rxd = 1'b1;
  endtask

  task automatic wait_tx_drain(input string tag, input int budget);
    int n = 0;
    while (exp_tx.size() != 0 && n < budget) begin
      wait_cycles(1);
      n++;
    end
    check(tag, 32'(exp_tx.size()), 32'd0);
  endtask

  task automatic wait_out_ready(input string tag, input int budget);
    int n = 0;
    while (out_ready !== 1'b1 && n < budget) begin
      wait_cycles(1);
      n++;
    end
    check(tag, 32'(out_ready), 32'd1);
  endtask

  task automatic read_word(input string tag, input int a, input logic [31:0] exp);
    imem_raddr = 10'(a);
    wait_cycles(1);
    check(tag, imem_rdata, exp);
  endtask

  task automatic do_reset_and_sync();
    reset_n = 1'b0;
    wait_cycles(3);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_boot_done", 32'(boot_done), 32'd0);
    check("rst_in_valid", 32'(in_valid), 32'd0);
    check("rst_out_ready", 32'(out_ready), 32'd0);
    check("rst_imem_rdata", imem_rdata, 32'd0);
    exp_tx.push_back(8'h99);
    reset_n = 1'b1;
    wait_cycles(1);
    check("sync_txd_idle", 32'(txd), 32'd1);
    wait_cycles(1);
    check("sync_start_fall", 32'(txd), 32'd0);
    wait_tx_drain("sync_frame", 20 * CPB);
    wait_cycles(CPB);
  endtask

  task automatic finish_ack(input string tag);
    wait_tx_drain(tag, 20 * CPB);
    check("boot_done_during_ack", 32'(boot_done), 32'd0);
    wait_cycles(CPB);
    check("boot_done_after_ack", 32'(boot_done), 32'd1);
  endtask

  // Host-side decoder of the DUT transmit line; compares against the scoreboard.
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(posedge clk);
      #1;
      if (txd === 1'b0) begin
        wait_cycles(CPB / 2);
        check("tx_start_bit", 32'(txd), 32'd0);
        check("out_ready_while_busy", 32'(out_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
          wait_cycles(CPB);
          b[i] = txd;
        end
        wait_cycles(CPB);
        check("tx_stop_bit", 32'(txd), 32'd1);
        if (exp_tx.size() == 0) check("tx_unexpected_byte", 32'(b), 32'hFFFF_FFFF);
        else                    check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset_n = 1'b0; rxd = 1'b1; in_ready = 1'b0;
    out_valid = 1'b0; out_data = 8'h00; imem_raddr = '0;

    // Boot 1: 128-byte program, back to back.
    do_reset_and_sync();
    for (int i = 0; i < 32; i++) prog[i] = $urandom;
    prog[0] = 32'h1234_5678;
    exp_tx.push_back(8'hAA);
    send_byte(8'h80, 1'b1);
    repeat (3) send_byte(8'h00, 1'b1);
    for (int i = 0; i < 32; i++)
      for (int k = 0; k < 4; k++) send_byte(prog[i][8*k +: 8], 1'b1);
    finish_ack("ack_128");
    for (int i = 0; i < 32; i++) read_word($sformatf("imem_word%0d", i), i, prog[i]);
    read_word("byte_order", 0, 32'h1234_5678);

    // stdin overflow with the core stalled.
    check("run_out_ready", 32'(out_ready), 32'd1);
    check("run_in_valid_empty", 32'(in_valid), 32'd0);
    for (int i = 0; i < 128; i++) begin
      if (exp_in.size() < DEPTH) exp_in.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    wait_cycles(2);
    for (int i = 0; i < int'(DEPTH); i++) begin
      check("fifo_valid", 32'(in_valid), 32'd1);
      check("fifo_data", 32'(in_data), 32'(exp_in.pop_front()));
      in_ready = 1'b1;
      wait_cycles(1);
      in_ready = 1'b0;
    end
    check("fifo_empty_after_pops", 32'(in_valid), 32'd0);

    // stdout: two bytes offered with out_valid held high.
    exp_tx.push_back(8'h41);
    exp_tx.push_back(8'h42);
    out_data = 8'h41;
    out_valid = 1'b1;
    wait_out_ready("out_ready_first", 4);
    wait_cycles(1);
    check("out_ready_after_accept", 32'(out_ready), 32'd0);
    out_data = 8'h42;
    wait_out_ready("out_ready_second", 20 * CPB);
    wait_cycles(1);
    out_valid = 1'b0;
    wait_tx_drain("out_frames", 20 * CPB);
    wait_cycles(CPB);
    check("out_ready_idle", 32'(out_ready), 32'd1);

    // Boot 2: size 6 with a framing-error byte inside the size field.
    do_reset_and_sync();
    exp_tx.push_back(8'hAA);
    send_byte(8'h06, 1'b1);
    send_byte(8'h55, 1'b0);
    rxd = 1'b1;
    wait_cycles(2 * CPB);
    repeat (3) send_byte(8'h00, 1'b1);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
    finish_ack("ack_6");
    read_word("partial_word0", 0, 32'h0403_0201);
    read_word("partial_word1", 1, 32'h0000_0605);

    // Boot 3: zero-length program goes straight to the acknowledge.
    do_reset_and_sync();
    exp_tx.push_back(8'hAA);
    repeat (4) send_byte(8'h00, 1'b1);
    finish_ack("ack_zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/miyajiro_cpu.md
# miyajiro_cpu

Top-level host-link shell of the MIYAJIRO CPU. It bundles a UART receiver (UART_RX), a UART transmitter (UART_TX), a boot loader that downloads the program image from the host into instruction memory, and byte-stream stdin/stdout channels toward the execution core. The host sees only the two UART pins. The core attaches through the imem read port and the in/out byte handshakes.

## Interface
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200 baud).
- IMEM_WORDS, 1024: instruction memory depth in 32-bit words.
- IN_FIFO_DEPTH, 16: stdin byte FIFO depth (power of two).
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cpu_uart_rxd  in  1  serial data from host, idles high.
- cpu_uart_txd  out  1  serial data to host, idles high.
- imem_raddr  in  $clog2(IMEM_WORDS)  core instruction word address.
- imem_rdata  out  32  instruction word, 1-cycle read latency.
- boot_done  out  1  high once 0xAA has been fully transmitted; core held off until then.
- in_valid  out  1  stdin FIFO non-empty.
- in_data  out  8  FIFO head byte.
- in_ready  in  1  core pops head when in_valid && in_ready.
- out_valid  in  1  core offers a stdout byte.
- out_data  in  8  stdout byte.
- out_ready  out  1  byte accepted when out_valid && out_ready.

## Operation
- UART format: 8N1, LSB first, 1 start bit (0), 8 data bits, 1 stop bit (1).
- UART_RX:
  - Samples the start bit at mid-bit, then each bit at CLKS_PER_BIT spacing.
  - Emits rdata plus a 1-cycle rdata_ready pulse at the stop-bit sample.
  - ferr = 1 with that pulse when the stop bit reads 0.
  - Any byte with ferr set is discarded by the loader and the FIFO.
- UART_TX:
  - tx_start is sampled only when not busy.
  - sdata is latched on the tx_start cycle.
  - tx_busy is high from the cycle after tx_start through the end of the stop bit.
- Loader states:
  - SEND_SYNC: transmit 0x99 once.
  - RX_SIZE: 4 bytes, little-endian, giving N program bytes.
  - RX_PROG: N bytes; bytes packed little-endian into words, byte k goes to bits [8*(k%4)+7 : 8*(k%4)] of word k/4.
  - SEND_ACK: transmit 0xAA.
  - RUN: boot_done = 1.
- Each word is written when its 4th byte arrives. If N%4 != 0, the final partial word is written zero-padded after the last byte.
- N = 0: go directly from RX_SIZE to SEND_ACK.
- Bytes whose word index is >= IMEM_WORDS are consumed but not written.
- In RUN:
  - Received bytes are pushed into the stdin FIFO. A push when full drops the byte.
  - out_ready = 1 when the TX is idle and no send is pending; an accepted byte is transmitted immediately.
- Before RUN: received bytes go to the loader only; out_ready = 0; in_valid = 0.
- Simultaneous FIFO push and pop on the same cycle are both performed, including when full (pop frees a slot) and when empty (byte passes through with 1-cycle latency).

## Timing
- Reset values: cpu_uart_txd = 1, boot_done = 0, in_valid = 0, out_ready = 0, imem_rdata = 0, FIFO empty, size register 0, loader in SEND_SYNC.
- Memory contents are not cleared by reset.
- tx_start for 0x99 is issued on the first cycle after reset_n is sampled high. The start bit appears on the following cycle.
- A full frame lasts 10*CLKS_PER_BIT cycles.
- rdata_ready pulses 9.5*CLKS_PER_BIT cycles (±1) after the start-bit falling edge.
- SEND_ACK begins the cycle after the last program byte's rdata_ready.
- boot_done rises the cycle after the 0xAA stop bit completes.
- Back-to-back host bytes with zero idle time between frames are received without loss.
- Reset asserted mid-frame or mid-load: everything returns to reset values at the next edge. The sequence restarts with 0x99 after release.

## Test plan
- Reset release: cpu_uart_txd emits frame 0x99 (bits 1,0,0,1,1,0,0,1 LSB first); its start bit falls 2 cycles after release.
- Size 128 followed by 32 words, back to back:
  - 0xAA is transmitted after the last byte.
  - imem word i reads program[i].
  - Byte order check: bytes 0x78,0x56,0x34,0x12 produce word 0x12345678.
- Size 6, bytes 01..06: word0 = 0x04030201, word1 = 0x00000605, then 0xAA.
- RUN with host sending 128 stdin bytes while the core holds in_ready low:
  - The first 16 bytes are kept in order; the rest are dropped.
  - Popping then returns bytes 0..15.
- Core pushes 0x41,0x42 with out_valid held high: two frames are transmitted back to back; out_ready is low while tx_busy.
- Host byte with stop bit 0 during RX_SIZE: the byte is ignored, the size is unaffected, and the load completes using the following valid bytes.
